// File: rtl/uart_operand_rx.sv
// UART operand receiver: deserialises 8N1/8E1/8O1 frames and
// packs them little-endian into a multi-word operand packet.
module uart_operand_rx #(
  parameter int CLK_PER_BIT  = 434,
  parameter int WORD_W       = 16,
  parameter int NUM_WORDS    = 3,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [NUM_WORDS*WORD_W-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err,
  output logic [2:0]                  err_code
);

  localparam int BPW    = WORD_W / 8;
  localparam int NBYTES = NUM_WORDS * BPW;
  localparam int DW     = NUM_WORDS * WORD_W;
  localparam int CW     = $clog2(CLK_PER_BIT);
  localparam int BIW    = $clog2(NBYTES + 1);
  localparam int TO_MAX = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int TW     = $clog2(TO_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic            rx_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      nbit_q, nbit_d;
  logic [7:0]      data_q, data_d;
  logic            par_bad_q, par_bad_d;
  logic [BIW-1:0]  bidx_q, bidx_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            wrap;

  assign rx_s      = sync_q[1];
  assign wrap      = (cnt_q == CW'(CLK_PER_BIT - 1));
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbit_d      = nbit_q;
    data_d      = data_q;
    par_bad_d   = par_bad_q;
    bidx_d      = bidx_q;
    idle_d      = '0;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        nbit_d = '0;
        if (rx_prev_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CW'(CLK_PER_BIT / 2)) begin
          cnt_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (wrap) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[7:1]};
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == 3'd7)
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if ((^data_q ^ rx_s) != (PARITY == 2)) begin
            par_bad_d  = 1'b1;
            err_d      = 1'b1;
            err_code_d = 3'd2;
            bidx_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          // parity already reported; a bad stop is not reported again
          if (par_bad_q) begin
            bidx_d = '0;
          end else if (!rx_s) begin
            err_d      = 1'b1;
            err_code_d = 3'd1;
            bidx_d     = '0;
          end else begin
            for (int i = 0; i < NBYTES; i++)
              if (bidx_q == BIW'(i)) shadow_d[i*8 +: 8] = data_q;
            if (bidx_q == BIW'(NBYTES - 1)) begin
              bidx_d = '0;
              if (!out_valid_q || out_ready) begin
                out_data_d  = shadow_d;
                out_valid_d = 1'b1;
              end else begin
                err_d      = 1'b1;
                err_code_d = 3'd4;
              end
            end else begin
              bidx_d = bidx_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // inter-byte idle watchdog, only inside a partial packet
    if (state_q == S_IDLE && state_d == S_IDLE && bidx_q != '0) begin
      if (idle_q == TW'(TO_MAX - 1)) begin
        bidx_d     = '0;
        err_d      = 1'b1;
        err_code_d = 3'd3;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nbit_q      <= '0;
      data_q      <= '0;
      par_bad_q   <= 1'b0;
      bidx_q      <= '0;
      idle_q      <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbit_q      <= nbit_d;
      data_q      <= data_d;
      par_bad_q   <= par_bad_d;
      bidx_q      <= bidx_d;
      idle_q      <= idle_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_operand_rx.sv
// Bench for uart_operand_rx: byte-level reference model feeds a
// scoreboard; a negedge monitor checks packets and error pulses.
module tb_uart_operand_rx;

  localparam int CPB    = 20;
  localparam int WW     = 16;
  localparam int NW     = 3;
  localparam int TB_PAR = 1;
  localparam int TOB    = 4;
  localparam int NB     = NW * WW / 8;
  localparam int DW     = NW * WW;
  localparam int TO_CLK = TOB * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic [2:0]    err_code;

  logic [DW-1:0] pkt_q[$];
  logic [2:0]    err_q[$];
  logic [7:0]    bq[$];
  bit            pending;
  logic [2:0]    last_code;
  int            checks;
  int            errors;

  uart_operand_rx #(
    .CLK_PER_BIT (CPB),
    .WORD_W      (WW),
    .NUM_WORDS   (NW),
    .PARITY      (TB_PAR),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic push_err(input logic [2:0] c);
    err_q.push_back(c);
    last_code = c;
  endtask

  task automatic set_ready(input logic v);
    out_ready = v;
    if (v) pending = 1'b0;
  endtask

  // Reference model: what one frame means at packet level
  task automatic model_byte(input logic [7:0] b, input bit bp,
                            input bit bs);
    logic [DW-1:0] p;
    if (bp) begin
      push_err(3'd2);
      bq.delete();
    end else if (bs) begin
      push_err(3'd1);
      bq.delete();
    end else begin
      bq.push_back(b);
      if (bq.size() == NB) begin
        p = '0;
        for (int i = 0; i < NB; i++) p[i*8 +: 8] = bq[i];
        bq.delete();
        if (!out_ready && pending) begin
          push_err(3'd4);
        end else begin
          pkt_q.push_back(p);
          pending = !out_ready;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp,
                            input bit bs);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
    rx = (^b) ^ (TB_PAR == 2) ^ bp;
    hold(CPB);
    rx = !bs;
    hold(CPB);
    rx = 1'b1;
    if (bs) hold(2 * CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp,
                           input bit bs, input int gap);
    model_byte(b, bp, bs);
    send_frame(b, bp, bs);
    hold(gap);
  endtask

  task automatic send_rand_pkt();
    for (int i = 0; i < NB; i++)
      send_byte(8'($urandom), 1'b0, 1'b0, $urandom_range(0, 4));
  endtask

  task automatic idle_long();
    if (bq.size() != 0) push_err(3'd3);
    bq.delete();
    hold(TO_CLK + 2 * CPB);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pkt_q.size() != 0 || err_q.size() != 0) && n < 4000) begin
      hold(1);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL drain: pkts %0d errs %0d still pending, want 0",
               pkt_q.size(), err_q.size());
      pkt_q.delete();
      err_q.delete();
    end
  endtask

  initial begin
    logic [DW-1:0] pd;
    bit pv;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (pv && out_valid) chk("hold", out_data, pd);
        if (out_valid && out_ready) begin
          if (pkt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pkt: got %h want none", out_data);
          end else begin
            chk("pkt", out_data, pkt_q.pop_front());
          end
        end
        if (err) begin
          if (err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL err: got code %0d want no err", err_code);
          end else begin
            chk("err_code", DW'(err_code), DW'(err_q.pop_front()));
          end
        end
        pv = out_valid && !out_ready;
        pd = out_data;
      end
    end
  end

  initial begin
    logic [7:0] clean [NB];
    logic [DW-1:0] pa;
    clean = '{8'h80, 8'h57, 8'h05, 8'h3D, 8'h02, 8'h00};
    checks    = 0;
    errors    = 0;
    pending   = 1'b0;
    last_code = 3'd0;
    rst       = 1'b0;
    rx        = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(4);
    chk("rst_data", out_data, '0);
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_err", DW'(err), '0);
    chk("rst_code", DW'(err_code), '0);

    // clean packet from the example stream
    for (int i = 0; i < NB; i++) send_byte(clean[i], 1'b0, 1'b0, 2);
    drain();

    // framing error on byte 3, then a clean packet
    for (int i = 0; i < 3; i++) send_byte(clean[i], 1'b0, 1'b0, 2);
    send_byte(8'h3D, 1'b0, 1'b1, 2);
    send_rand_pkt();
    drain();

    // parity error mid-packet, then the same byte accepted
    send_byte(8'h11, 1'b0, 1'b0, 2);
    send_byte(8'h22, 1'b0, 1'b0, 2);
    send_byte(8'h57, 1'b1, 1'b0, 2);
    send_byte(8'h57, 1'b0, 1'b0, 2);
    for (int i = 1; i < NB; i++)
      send_byte(8'($urandom), 1'b0, 1'b0, 1);
    send_byte(8'hA5, 1'b1, 1'b1, 2);
    drain();

    // inter-byte timeout, then a full packet
    send_byte(8'h80, 1'b0, 1'b0, 0);
    send_byte(8'h57, 1'b0, 1'b0, 0);
    idle_long();
    send_rand_pkt();
    drain();

    // short low glitches produce nothing
    rx = 1'b0;
    hold(CPB / 4);
    rx = 1'b1;
    hold(2 * CPB);
    rx = 1'b0;
    hold(1);
    rx = 1'b1;
    hold(2 * CPB);
    send_rand_pkt();
    drain();

    // overrun: A kept, B dropped
    set_ready(1'b0);
    for (int i = 0; i < NB; i++) pa[i*8 +: 8] = 8'($urandom);
    for (int i = 0; i < NB; i++) send_byte(pa[i*8 +: 8], 1'b0, 1'b0, 2);
    send_rand_pkt();
    hold(CPB);
    chk("ovr_valid", DW'(out_valid), DW'(1));
    chk("ovr_data", out_data, pa);
    set_ready(1'b1);
    hold(1);
    chk("ovr_clear", DW'(out_valid), '0);
    drain();

    // reset in the middle of byte 2
    send_byte(8'hC3, 1'b0, 1'b0, 1);
    send_byte(8'h3C, 1'b0, 1'b0, 1);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      hold(CPB);
    end
    rst = 1'b0;
    rx  = 1'b1;
    hold(3);
    bq.delete();
    last_code = 3'd0;
    chk("mrst_data", out_data, '0);
    chk("mrst_valid", DW'(out_valid), '0);
    chk("mrst_err", DW'(err), '0);
    chk("mrst_code", DW'(err_code), '0);
    rst = 1'b1;
    hold(2 * CPB);
    send_rand_pkt();
    drain();

    // random stream with sporadic errors and consumer stalls
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (bq.size() == NB - 1) set_ready(1'b1);
      else set_ready(1'($urandom));
      send_byte(8'($urandom), r == 0 || r == 2, r == 1 || r == 2,
                $urandom_range(0, CPB));
    end
    set_ready(1'b1);
    idle_long();
    drain();
    hold(CPB);
    chk("code_hold", DW'(err_code), DW'(last_code));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
